// File: rtl/pwm_generator.sv
// PWM generator for a motor bridge: 256-tick period with a programmable
// prescaler, ratio updates applied only at period boundaries, and a
// forced-low dead time of DEAD_PERIODS full periods on direction reversal.
module pwm_generator #(
  parameter int unsigned DEAD_PERIODS = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pwm_enable,
  input  logic       pwm_update,
  input  logic [7:0] pwm_ratio,
  input  logic       pwm_direction,
  input  logic [7:0] pwm_div,
  output logic       pwm_done,
  output logic       pwm_out,
  output logic       dir_out,
  output logic [7:0] active_ratio
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_PERIODS);

  state_t     r_state;
  logic [7:0] r_prescale_cnt;
  logic [7:0] r_period_cnt;
  logic [7:0] r_dead_cnt;
  logic       r_pwm_out;
  logic       r_pwm_done;
  logic [7:0] r_active_ratio;
  logic       r_dir_out;

  state_t     w_state_next;
  logic [7:0] w_prescale_next;
  logic [7:0] w_period_next;
  logic [7:0] w_dead_next;
  logic       w_pwm_out_next;
  logic       w_pwm_done_next;
  logic [7:0] w_ratio_next;
  logic       w_dir_next;

  logic       w_tick;
  logic       w_boundary;
  logic [7:0] w_prescale_wrap;
  logic [7:0] w_period_adv;

  // A count left above a freshly lowered pwm_div wraps on the next clock
  // instead of running all the way round to 255.
  assign w_tick          = (r_prescale_cnt == pwm_div);
  assign w_prescale_wrap = (r_prescale_cnt >= pwm_div) ? 8'd0 : r_prescale_cnt + 8'd1;
  assign w_period_adv    = w_tick ? r_period_cnt + 8'd1 : r_period_cnt;
  assign w_boundary      = w_tick && (r_period_cnt == 8'd255);

  // Next-state and next-output decode for the IDLE/RUN/DEAD controller.
  always_comb begin
    // NOTE: every target gets a default before any branch so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    w_state_next    = r_state;
    w_prescale_next = r_prescale_cnt;
    w_period_next   = r_period_cnt;
    w_dead_next     = r_dead_cnt;
    w_pwm_out_next  = 1'b0;
    w_pwm_done_next = 1'b0;
    w_ratio_next    = r_active_ratio;
    w_dir_next      = r_dir_out;

    if (!pwm_enable) begin
      w_state_next    = S_IDLE;
      w_prescale_next = 8'd0;
      w_period_next   = 8'd0;
      w_dead_next     = 8'd0;
      w_ratio_next    = 8'd0;
      if (r_state == S_IDLE) w_dir_next = pwm_direction;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // Counters stay parked so the first RUN period starts from zero;
          // direction follows the request because the motor is stopped.
          w_state_next    = S_RUN;
          w_prescale_next = 8'd0;
          w_period_next   = 8'd0;
          w_dead_next     = 8'd0;
          w_ratio_next    = 8'd0;
          w_dir_next      = pwm_direction;
        end
        S_RUN: begin
          w_prescale_next = w_prescale_wrap;
          w_period_next   = w_period_adv;
          w_pwm_out_next  = (r_period_cnt < r_active_ratio);
          if (w_boundary && pwm_update) begin
            if (pwm_direction == r_dir_out) begin
              w_ratio_next    = pwm_ratio;
              w_pwm_done_next = 1'b1;
            end else begin
              w_state_next = S_DEAD;
              w_dead_next  = DEAD_LOAD;
            end
          end
        end
        S_DEAD: begin
          w_prescale_next = w_prescale_wrap;
          w_period_next   = w_period_adv;
          if (w_boundary) begin
            if (r_dead_cnt <= 8'd1) begin
              w_state_next = S_RUN;
              w_dead_next  = 8'd0;
              // A request withdrawn during the dead time leaves the bridge
              // at zero drive rather than reviving the stale ratio.
              if (pwm_update) begin
                w_dir_next      = pwm_direction;
                w_ratio_next    = pwm_ratio;
                w_pwm_done_next = 1'b1;
              end else begin
                w_ratio_next = 8'd0;
              end
            end else begin
              w_dead_next = r_dead_cnt - 8'd1;
            end
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_prescale_cnt <= 8'd0;
      r_period_cnt   <= 8'd0;
      r_dead_cnt     <= 8'd0;
      r_pwm_out      <= 1'b0;
      r_pwm_done     <= 1'b0;
      r_active_ratio <= 8'd0;
      r_dir_out      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      r_state        <= w_state_next;
      r_prescale_cnt <= w_prescale_next;
      r_period_cnt   <= w_period_next;
      r_dead_cnt     <= w_dead_next;
      r_pwm_out      <= w_pwm_out_next;
      r_pwm_done     <= w_pwm_done_next;
      r_active_ratio <= w_ratio_next;
      r_dir_out      <= w_dir_next;
    end
  end

  assign pwm_done     = r_pwm_done;
  assign pwm_out      = r_pwm_out;
  assign dir_out      = r_dir_out;
  assign active_ratio = r_active_ratio;

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: a scoreboard of expected activations is
// filled as requests are driven and drained on every pwm_done pulse.
module tb_pwm_generator;

  logic       clock;
  logic       reset_n;
  logic       pwm_enable;
  logic       pwm_update;
  logic [7:0] pwm_ratio;
  logic       pwm_direction;
  logic [7:0] pwm_div;
  logic       pwm_done;
  logic       pwm_out;
  logic       dir_out;
  logic [7:0] active_ratio;

  typedef struct packed {
    logic [7:0] ratio;
    logic       dir;
  } exp_t;

  exp_t sb_q[$];
  int   n_asserts = 0;
  int   n_fail    = 0;
  logic prev_done = 1'b0;

  pwm_generator #(.DEAD_PERIODS(1)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pwm_enable   (pwm_enable),
    .pwm_update   (pwm_update),
    .pwm_ratio    (pwm_ratio),
    .pwm_direction(pwm_direction),
    .pwm_div      (pwm_div),
    .pwm_done     (pwm_done),
    .pwm_out      (pwm_out),
    .dir_out      (dir_out),
    .active_ratio (active_ratio)
  );

  // 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard drain: every pwm_done must match the oldest outstanding request.
  always @(negedge clock) begin
    if (pwm_done === 1'b1) begin
      exp_t e;
      check("done_single_cycle", {31'd0, prev_done}, 32'd0);
      check("done_expected", {31'd0, (sb_q.size() != 0)}, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("done_ratio", {24'd0, active_ratio}, {24'd0, e.ratio});
        check("done_dir", {31'd0, dir_out}, {31'd0, e.dir});
      end
    end
    prev_done = pwm_done;
  end

  // Wait for the next pwm_done, counting clocks and pwm_out high samples.
  task automatic wait_done(input int budget, input string tag,
                           output int elapsed, output int highs);
    bit found;
    found   = 1'b0;
    elapsed = 0;
    highs   = 0;
    while (!found && elapsed < budget) begin
      @(negedge clock);
      elapsed++;
      if (pwm_out) highs++;
      if (pwm_done) found = 1'b1;
    end
    check(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic measure(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (pwm_out) highs++;
    end
  endtask

  task automatic request(input logic [7:0] ratio, input logic dir);
    exp_t e;
    pwm_ratio     = ratio;
    pwm_direction = dir;
    pwm_update    = 1'b1;
    e.ratio       = ratio;
    e.dir         = dir;
    sb_q.push_back(e);
  endtask

  initial begin
    int el;
    int hi;
    int n;
    reset_n       = 1'b0;
    pwm_enable    = 1'b0;
    pwm_update    = 1'b0;
    pwm_ratio     = 8'd0;
    pwm_direction = 1'b0;
    pwm_div       = 8'd0;
    repeat (3) @(negedge clock);

    // Reset state.
    check("rst_pwm_out", {31'd0, pwm_out}, 32'd0);
    check("rst_done", {31'd0, pwm_done}, 32'd0);
    check("rst_ratio", {24'd0, active_ratio}, 32'd0);
    check("rst_dir", {31'd0, dir_out}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // div=0, ratio 64: activation after the first 256-clock period, 64/256 duty.
    pwm_enable = 1'b1;
    request(8'd64, 1'b0);
    wait_done(400, "a_done", el, hi);
    check("a_latency", el, 32'd257);
    pwm_update = 1'b0;
    measure(256, hi);
    check("a_duty", hi, 32'd64);
    check("a_ratio_held", {24'd0, active_ratio}, 32'd64);

    // div=3, ratio 128: 1024-clock period, done every period while update held.
    pwm_div = 8'd3;
    request(8'd128, 1'b0);
    wait_done(2100, "b_done1", el, hi);
    request(8'd128, 1'b0);
    wait_done(1100, "b_done2", el, hi);
    check("b_period", el, 32'd1024);
    pwm_update = 1'b0;
    measure(1024, hi);
    check("b_duty", hi, 32'd512);

    // Mid-period change 50->180: current period completes at 50.
    pwm_div = 8'd0;
    request(8'd50, 1'b0);
    wait_done(2100, "c_done50", el, hi);
    measure(128, hi);
    check("c_half_high", hi, 32'd50);
    request(8'd180, 1'b0);
    check("c_mid_ratio", {24'd0, active_ratio}, 32'd50);
    wait_done(300, "c_done180", el, hi);
    check("c_apply_boundary", el, 32'd128);
    pwm_update = 1'b0;
    measure(256, hi);
    check("c_duty", hi, 32'd180);

    // Ratio extremes.
    request(8'd0, 1'b0);
    wait_done(300, "d_done0", el, hi);
    pwm_update = 1'b0;
    measure(256, hi);
    check("d_duty0", hi, 32'd0);
    request(8'd255, 1'b0);
    wait_done(300, "d_done255", el, hi);
    pwm_update = 1'b0;
    measure(256, hi);
    check("d_duty255", hi, 32'd255);

    // Reversal 200/dir0 -> 100/dir1 with one dead period.
    request(8'd200, 1'b0);
    wait_done(300, "e_done200", el, hi);
    request(8'd100, 1'b1);
    measure(256, hi);
    check("e_last_run_duty", hi, 32'd200);
    check("e_dir_held", {31'd0, dir_out}, 32'd0);
    wait_done(300, "e_done_rev", el, hi);
    check("e_dead_len", el, 32'd256);
    check("e_dead_low", hi, 32'd0);
    pwm_update = 1'b0;
    measure(256, hi);
    check("e_duty100", hi, 32'd100);

    // Disable mid-high-time.
    n = 0;
    while (pwm_out !== 1'b1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("f_saw_high", {31'd0, pwm_out}, 32'd1);
    pwm_enable = 1'b0;
    @(negedge clock);
    check("f_out_low", {31'd0, pwm_out}, 32'd0);
    check("f_ratio_clr", {24'd0, active_ratio}, 32'd0);
    check("f_no_done", {31'd0, pwm_done}, 32'd0);
    pwm_direction = 1'b0;
    @(negedge clock);
    check("f_idle_dir_track", {31'd0, dir_out}, 32'd0);

    // Update dropped during DEAD: dead time completes, ratio goes to 0.
    pwm_enable = 1'b1;
    request(8'd80, 1'b0);
    wait_done(400, "g_done80", el, hi);
    check("g_latency", el, 32'd257);
    pwm_direction = 1'b1;
    repeat (300) @(negedge clock);
    check("g_dead_ratio_kept", {24'd0, active_ratio}, 32'd80);
    check("g_dead_out_low", {31'd0, pwm_out}, 32'd0);
    pwm_update = 1'b0;
    repeat (256) @(negedge clock);
    check("g_abort_ratio0", {24'd0, active_ratio}, 32'd0);

    // Reset pulsed during DEAD clears state immediately.
    pwm_ratio  = 8'd100;
    pwm_update = 1'b1;
    repeat (300) @(negedge clock);
    check("h_in_dead_low", {31'd0, pwm_out}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("h_rst_out", {31'd0, pwm_out}, 32'd0);
    check("h_rst_ratio", {24'd0, active_ratio}, 32'd0);
    check("h_rst_dir", {31'd0, dir_out}, 32'd0);
    check("h_rst_done", {31'd0, pwm_done}, 32'd0);
    pwm_enable = 1'b0;
    pwm_update = 1'b0;
    #1 reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("h_post_ratio", {24'd0, active_ratio}, 32'd0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 Parameter DEAD_PERIODS, default 1: number of full PWM periods with output forced low on a direction reversal.
REQ-002 clock  input  1  main clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 pwm_enable  input  1  block enable; low forces IDLE.
REQ-005 pwm_update  input  1  level request from the angle controller; pwm_ratio/pwm_direction are valid while high.
REQ-006 pwm_ratio  input  8  requested high-time, in ticks, out of 256.
REQ-007 pwm_direction  input  1  requested motor direction.
REQ-008 pwm_div  input  8  prescaler; one tick every pwm_div+1 clocks.
REQ-009 pwm_done  output  1  one-clock pulse when a requested ratio becomes active.
REQ-010 pwm_out  output  1  PWM drive to the motor bridge.
REQ-011 dir_out  output  1  applied motor direction.
REQ-012 active_ratio  output  8  ratio currently being generated.

Function
REQ-013 The prescale counter (8 bits) shall count 0..pwm_div and raise an internal tick on the clock where it equals pwm_div, then return to 0.
REQ-014 The period counter (8 bits) shall advance by 1 on each tick and wrap 255->0; the period is 256 ticks = 256*(pwm_div+1) clocks.
REQ-015 pwm_out shall be registered and equal (period_cnt < active_ratio) in RUN; ratio 0 gives constant low, 255 gives 255/256 high.
REQ-016 States: IDLE, RUN, DEAD.
REQ-017 IDLE: both counters held at 0, pwm_out=0, active_ratio=0, pwm_done=0; pwm_enable=1 moves to RUN next clock.
REQ-018 A period boundary is the clock where tick=1 and period_cnt=255.
REQ-019 RUN, at a boundary with pwm_update=1 and pwm_direction==dir_out: active_ratio<=pwm_ratio and pwm_done pulses high for exactly that next clock.
REQ-020 RUN, at a boundary with pwm_update=1 and pwm_direction!=dir_out: go to DEAD, load dead-period counter with DEAD_PERIODS, keep active_ratio, no pwm_done.
REQ-021 RUN, at a boundary with pwm_update=0: active_ratio unchanged, no pwm_done.
REQ-022 Inputs shall be sampled only at boundaries; mid-period changes of pwm_ratio/pwm_direction shall have no effect.
REQ-023 DEAD: pwm_out=0; the dead counter decrements at each boundary; at the boundary where it reaches 1, dir_out<=sampled pwm_direction, active_ratio<=pwm_ratio sampled at that boundary, pwm_done pulses, and the state returns to RUN.
REQ-024 A pwm_update drop during DEAD shall not abort the dead time; at its end active_ratio<=0 and pwm_done shall not pulse.
REQ-025 In IDLE, dir_out shall track pwm_direction each clock (no dead time from standstill).
REQ-026 pwm_enable=0 in any state shall move to IDLE on the next clock and force pwm_out=0 on that same clock edge.
REQ-027 A pwm_div change shall take effect at the next prescale wrap; a count above the new pwm_div shall wrap to 0 on the next clock.
REQ-028 pwm_done shall never be high on two consecutive clocks, so every activation presents a fresh rising edge.

Reset
REQ-029 During reset: state=IDLE, counters=0, dead counter=0, pwm_out=0, pwm_done=0, active_ratio=0, dir_out=0.
REQ-030 A reset asserted mid-period or mid-DEAD shall clear all state immediately; after reset release, operation shall start from IDLE.

Verification
REQ-031 pwm_div=0, enable=1, update=1, ratio=64, dir=0 -> pwm_done pulses after the first 256-clock period; afterwards pwm_out is high for 64 of every 256 clocks.
REQ-032 pwm_div=3, ratio=128 -> period = 1024 clocks; high for 512 clocks; pwm_done pulses every 1024 clocks while update=1.
REQ-033 Running at ratio=200 with dir=0, then dir switched to 1 with ratio=100, DEAD_PERIODS=1 -> pwm_out low for a full period, then dir_out=1, a pwm_done pulse, and 100/256 duty.
REQ-034 Ratio changed 50->180 mid-period -> the current period completes at 50; 180 applies from the next boundary, with one pwm_done pulse.
REQ-035 Ratio=0 and ratio=255 -> pwm_out is constant 0, or high except during one tick per period.
REQ-036 pwm_enable deasserted mid-high-time, or reset_n pulsed during DEAD -> pwm_out=0 on the next edge (or immediately for reset), active_ratio=0, and no pwm_done.
